// File: rtl/i2c_cmd_sequencer_if.sv
// Command/bus bundle between the I2C command sequencer and its client, bit layer and byte layer.
// The sequencer uses the slave modport; whoever issues commands and answers phases uses master.
interface i2c_cmd_sequencer_if #(
    parameter int unsigned ALEN  = 7,
    parameter int unsigned LEN_W = 24
);
    logic [3:0]       cmd;
    logic             cmd_vld;
    logic             cmd_ready;
    logic             cmd_finish;
    logic             cmd_err;
    logic [9:0]       addr;
    logic [LEN_W-1:0] wr_len;
    logic [LEN_W-1:0] rd_len;
    logic [3:0]       curr_status;
    logic             exec_addr;
    logic             exec_addr_rw;
    logic [ALEN-1:0]  address_curr;
    logic [LEN_W-1:0] exec_len;
    logic             exec_addr_finish;
    logic             exec_addr_nack;
    logic             exec_wr;
    logic             exec_wr_finish;
    logic             exec_wr_nack;
    logic             exec_rd;
    logic             exec_rd_finish;
    logic             tras_cmd_vld;
    logic [2:0]       tras_cmd;
    logic             tras_cmd_ready;
    logic             wfifo_rst;
    logic             rfifo_rst;
    logic             wfifo_empty;
    logic             rfifo_empty;

    modport master (
        output cmd, cmd_vld, addr, wr_len, rd_len,
        output exec_addr_finish, exec_addr_nack, exec_wr_finish, exec_wr_nack, exec_rd_finish,
        output tras_cmd_ready, wfifo_empty, rfifo_empty,
        input  cmd_ready, cmd_finish, cmd_err, curr_status,
        input  exec_addr, exec_addr_rw, address_curr, exec_len, exec_wr, exec_rd,
        input  tras_cmd_vld, tras_cmd, wfifo_rst, rfifo_rst
    );

    modport slave (
        input  cmd, cmd_vld, addr, wr_len, rd_len,
        input  exec_addr_finish, exec_addr_nack, exec_wr_finish, exec_wr_nack, exec_rd_finish,
        input  tras_cmd_ready, wfifo_empty, rfifo_empty,
        output cmd_ready, cmd_finish, cmd_err, curr_status,
        output exec_addr, exec_addr_rw, address_curr, exec_len, exec_wr, exec_rd,
        output tras_cmd_vld, tras_cmd, wfifo_rst, rfifo_rst
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// I2C command sequencer: turns one command into START / address / data / STOP phases with
// per-stage timeout, NACK handling and a held-bus flag for no-stop transfers.
module i2c_cmd_sequencer #(
    parameter int unsigned ALEN  = 7,
    parameter int unsigned LEN_W = 24,
    parameter int unsigned TMO_W = 16
) (
    input  logic               clock,
    input  logic               rst,
    i2c_cmd_sequencer_if.slave bus
);
    localparam logic [3:0] CmdWrStop   = 4'd1;
    localparam logic [3:0] CmdWrNostop = 4'd2;
    localparam logic [3:0] CmdRdStop   = 4'd3;
    localparam logic [3:0] CmdRdNostop = 4'd4;
    localparam logic [3:0] CmdFifoRst  = 4'd5;
    localparam logic [3:0] CmdWrRd     = 4'd6;
    localparam logic [2:0] TrasStart   = 3'd1;
    localparam logic [2:0] TrasStop    = 3'd4;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StGetCmd  = 4'd1,
        StStart   = 4'd2,
        StAddr    = 4'd3,
        StWr      = 4'd4,
        StRestart = 4'd5,
        StRd      = 4'd6,
        StStop    = 4'd7,
        StFifoRst = 4'd8,
        StFinish  = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cmd_q;
    logic [LEN_W-1:0] wr_len_q;
    logic [LEN_W-1:0] rd_len_q;
    logic [TMO_W-1:0] tmo_q;
    logic             err_q, err_d;
    logic             bus_held;

    logic accept, tmo_hit, nack, cmd_legal, cmd_rd_type, cmd_nostop, rw_d, entering;
    logic unused_addr;

    assign accept      = bus.cmd_vld && bus.cmd_ready;
    assign tmo_hit     = &tmo_q;
    assign nack        = bus.exec_addr_nack || bus.exec_wr_nack;
    assign cmd_legal   = (cmd_q >= CmdWrStop) && (cmd_q <= CmdWrRd);
    assign cmd_rd_type = (cmd_q == CmdRdStop) || (cmd_q == CmdRdNostop) || (cmd_q == CmdWrRd);
    assign cmd_nostop  = (cmd_q == CmdWrNostop) || (cmd_q == CmdRdNostop);
    // Second address phase of WR_RD (after RESTART) and plain reads address with R/W = 1.
    assign rw_d        = (cmd_q == CmdRdStop) || (cmd_q == CmdRdNostop) || (state_q == StRestart);
    assign entering    = (state_d != state_q);
    assign unused_addr = ^(bus.addr >> ALEN);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StGetCmd;
                    err_d   = 1'b0;
                end
            end
            StGetCmd: begin
                if (!cmd_legal || (cmd_rd_type && (rd_len_q == '0))) begin
                    state_d = StFinish;
                    err_d   = 1'b1;
                end else if (cmd_q == CmdFifoRst) begin
                    state_d = StFifoRst;
                end else begin
                    state_d = StStart;
                end
            end
            StStart, StRestart: begin
                if (bus.tras_cmd_vld && bus.tras_cmd_ready) begin
                    state_d = StAddr;
                end else if (tmo_hit) begin
                    state_d = StStop;
                    err_d   = 1'b1;
                end
            end
            StAddr: begin
                if (nack) begin
                    state_d = StStop;
                    err_d   = 1'b1;
                end else if (bus.exec_addr && bus.exec_addr_finish) begin
                    if (bus.exec_addr_rw)           state_d = StRd;
                    else if (wr_len_q != '0)        state_d = StWr;
                    else if (cmd_q == CmdWrRd)      state_d = StRestart;
                    else if (cmd_q == CmdWrStop)    state_d = StStop;
                    else                            state_d = StFinish;
                end else if (tmo_hit) begin
                    state_d = StStop;
                    err_d   = 1'b1;
                end
            end
            StWr: begin
                if (nack) begin
                    state_d = StStop;
                    err_d   = 1'b1;
                end else if (bus.exec_wr && bus.exec_wr_finish) begin
                    if (cmd_q == CmdWrRd)           state_d = StRestart;
                    else if (cmd_q == CmdWrStop)    state_d = StStop;
                    else                            state_d = StFinish;
                end else if (tmo_hit) begin
                    state_d = StStop;
                    err_d   = 1'b1;
                end
            end
            StRd: begin
                if (bus.exec_rd && bus.exec_rd_finish) begin
                    state_d = (cmd_q == CmdRdNostop) ? StFinish : StStop;
                end else if (tmo_hit) begin
                    state_d = StStop;
                    err_d   = 1'b1;
                end
            end
            StStop: begin
                if (bus.tras_cmd_vld && bus.tras_cmd_ready) begin
                    state_d = StFinish;
                end else if (tmo_hit) begin
                    state_d = StFinish;
                    err_d   = 1'b1;
                end
            end
            StFifoRst: begin
                // Emptiness is only trusted once the reset pulse has gone away.
                if (!bus.wfifo_rst && bus.wfifo_empty && bus.rfifo_empty) begin
                    state_d = StFinish;
                end else if (tmo_hit) begin
                    state_d = StFinish;
                    err_d   = 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            cmd_q            <= '0;
            wr_len_q         <= '0;
            rd_len_q         <= '0;
            tmo_q            <= '0;
            err_q            <= 1'b0;
            bus_held         <= 1'b0;
            bus.cmd_ready    <= 1'b0;
            bus.cmd_finish   <= 1'b0;
            bus.cmd_err      <= 1'b0;
            bus.curr_status  <= '0;
            bus.exec_addr    <= 1'b0;
            bus.exec_addr_rw <= 1'b0;
            bus.address_curr <= '0;
            bus.exec_len     <= '0;
            bus.exec_wr      <= 1'b0;
            bus.exec_rd      <= 1'b0;
            bus.tras_cmd_vld <= 1'b0;
            bus.tras_cmd     <= '0;
            bus.wfifo_rst    <= 1'b0;
            bus.rfifo_rst    <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_q           <= err_d;
            tmo_q           <= entering ? '0 : tmo_q + 1'b1;
            bus.curr_status <= state_d;
            bus.cmd_ready   <= (state_d == StIdle);
            bus.cmd_finish  <= (state_d == StFinish);

            if (accept) begin
                cmd_q            <= bus.cmd;
                wr_len_q         <= bus.wr_len;
                rd_len_q         <= bus.rd_len;
                bus.address_curr <= bus.addr[ALEN-1:0];
                bus.cmd_err      <= 1'b0;
            end else if (entering && (state_d == StFinish)) begin
                bus.cmd_err <= err_d;
            end

            if (entering && (state_d == StFinish)) begin
                if (state_q == StStop)           bus_held <= 1'b0;
                else if (!err_d && cmd_nostop)   bus_held <= 1'b1;
            end

            bus.exec_addr <= (state_d == StAddr);
            if (state_d != StAddr)   bus.exec_addr_rw <= 1'b0;
            else if (entering)       bus.exec_addr_rw <= rw_d;

            bus.exec_wr <= (state_d == StWr);
            bus.exec_rd <= (state_d == StRd);
            if (state_d == StWr)      bus.exec_len <= wr_len_q;
            else if (state_d == StRd) bus.exec_len <= rd_len_q;
            else                      bus.exec_len <= '0;

            bus.tras_cmd_vld <= (state_d == StStart) || (state_d == StRestart) ||
                                (state_d == StStop);
            if (state_d == StStop)                                bus.tras_cmd <= TrasStop;
            else if ((state_d == StStart) || (state_d == StRestart)) bus.tras_cmd <= TrasStart;
            else                                                  bus.tras_cmd <= '0;

            bus.wfifo_rst <= entering && (state_d == StFifoRst);
            bus.rfifo_rst <= entering && (state_d == StFifoRst);
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: a vector table of whole commands answered by an
// immediate-ack bus responder, plus hand sequences for FIFO timeout and reset during WR.
module tb_i2c_cmd_sequencer;
    localparam int unsigned ALEN  = 7;
    localparam int unsigned LEN_W = 24;
    localparam int unsigned TMO_W = 4;

    logic clock = 1'b0;
    logic rst   = 1'b0;

    i2c_cmd_sequencer_if #(.ALEN(ALEN), .LEN_W(LEN_W)) bus ();

    i2c_cmd_sequencer #(.ALEN(ALEN), .LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  cmd;
        logic [9:0]  addr;
        logic [23:0] wl;
        logic [23:0] rl;
        logic [1:0]  nack;   // 0 none, 1 address NACK (with finish), 2 write NACK
        logic        err;
        int          starts;
        int          stops;
        int          addrs;
        logic [7:0]  rw;
        logic [47:0] lens;
        logic [63:0] st;
        logic        held;
    } vec_t;

    vec_t vecs [15];

    int n_checks = 0;
    int n_fail   = 0;
    int epoch    = 0;
    int seen_epoch = 0;
    logic       hold_wr  = 1'b0;
    logic [1:0] nack_sel = 2'd0;

    int          starts, stops, addrs, vld_cycles, wpulses, rpulses, fifo_wait;
    logic [7:0]  rw_log;
    logic [47:0] len_log;
    logic [63:0] st_log;
    logic [3:0]  last_st = 4'd0;

    // Responder and monitor: answer requests immediately, log what completes on the next edge.
    always @(negedge clock) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            starts = 0; stops = 0; addrs = 0; vld_cycles = 0;
            wpulses = 0; rpulses = 0; fifo_wait = 0;
            rw_log = '0; len_log = '0; st_log = '0;
            last_st = bus.curr_status;
        end
        bus.tras_cmd_ready   = bus.tras_cmd_vld;
        bus.exec_addr_finish = bus.exec_addr;
        bus.exec_addr_nack   = bus.exec_addr && (nack_sel == 2'd1);
        bus.exec_wr_finish   = bus.exec_wr && !hold_wr;
        bus.exec_wr_nack     = bus.exec_wr && (nack_sel == 2'd2);
        bus.exec_rd_finish   = bus.exec_rd;
        if (bus.tras_cmd_vld) vld_cycles++;
        if (bus.tras_cmd_vld && bus.tras_cmd == 3'd1) starts++;
        if (bus.tras_cmd_vld && bus.tras_cmd == 3'd4) stops++;
        if (bus.exec_addr && !bus.exec_addr_nack) begin
            addrs++;
            rw_log = {rw_log[6:0], bus.exec_addr_rw};
        end
        if (bus.exec_wr && bus.exec_wr_finish && !bus.exec_wr_nack)
            len_log = {len_log[23:0], bus.exec_len};
        if (bus.exec_rd) len_log = {len_log[23:0], bus.exec_len};
        if (bus.wfifo_rst) wpulses++;
        if (bus.rfifo_rst) rpulses++;
        if (bus.curr_status == 4'd8) fifo_wait++;
        if (bus.curr_status != last_st) begin
            st_log  = {st_log[59:0], bus.curr_status};
            last_st = bus.curr_status;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {16'd0, bus.cmd_ready, bus.cmd_finish, bus.cmd_err, bus.curr_status,
                bus.exec_addr, bus.exec_addr_rw, bus.address_curr, bus.exec_len,
                bus.exec_wr, bus.exec_rd, bus.tras_cmd_vld, bus.tras_cmd,
                bus.wfifo_rst, bus.rfifo_rst};
    endfunction

    task automatic issue(input string tag, input logic [3:0] c, input logic [9:0] a,
                         input logic [23:0] wl, input logic [23:0] rl);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clock); #2;
            n++;
        end
        check({tag, "_ready"}, bus.cmd_ready, 1);
        epoch++;
        bus.cmd = c; bus.addr = a; bus.wr_len = wl; bus.rd_len = rl;
        bus.cmd_vld = 1'b1;
        @(posedge clock); #2;
        bus.cmd_vld = 1'b0;
        check({tag, "_busy"}, bus.cmd_ready, 0);
    endtask

    task automatic wait_finish(input string tag, output logic err);
        int n = 0;
        do begin
            @(posedge clock); #2;
            n++;
        end while (!bus.cmd_finish && n < 200);
        check({tag, "_finish"}, bus.cmd_finish, 1);
        err = bus.cmd_err;
        repeat (2) @(posedge clock);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic err;
        string t;
        int n;

        //          cmd    addr     wl      rl     nack  err s  p  a  rw     lens                st                   held
        vecs[0]  = '{4'd1, 10'h050, 24'd3, 24'd0, 2'd0, 1'b0, 1, 1, 1, 8'h00, 48'h3,            64'h1234790,         1'b0};
        vecs[1]  = '{4'd6, 10'h021, 24'd1, 24'd4, 2'd0, 1'b0, 2, 1, 2, 8'h01, 48'h000001000004, 64'h1234536790,      1'b0};
        vecs[2]  = '{4'd2, 10'h033, 24'd2, 24'd0, 2'd0, 1'b0, 1, 0, 1, 8'h00, 48'h2,            64'h123490,          1'b1};
        vecs[3]  = '{4'd3, 10'h033, 24'd0, 24'd5, 2'd0, 1'b0, 1, 1, 1, 8'h01, 48'h5,            64'h1236790,         1'b0};
        vecs[4]  = '{4'd1, 10'h010, 24'd2, 24'd0, 2'd1, 1'b1, 1, 1, 0, 8'h00, 48'h0,            64'h123790,          1'b0};
        vecs[5]  = '{4'd6, 10'h011, 24'd2, 24'd2, 2'd2, 1'b1, 1, 1, 1, 8'h00, 48'h0,            64'h1234790,         1'b0};
        vecs[6]  = '{4'd9, 10'h012, 24'd1, 24'd1, 2'd0, 1'b1, 0, 0, 0, 8'h00, 48'h0,            64'h190,             1'b0};
        vecs[7]  = '{4'd4, 10'h013, 24'd0, 24'd0, 2'd0, 1'b1, 0, 0, 0, 8'h00, 48'h0,            64'h190,             1'b0};
        vecs[8]  = '{4'd5, 10'h014, 24'd0, 24'd0, 2'd0, 1'b0, 0, 0, 0, 8'h00, 48'h0,            64'h1890,            1'b0};
        vecs[9]  = '{4'd4, 10'h055, 24'd0, 24'd2, 2'd0, 1'b0, 1, 0, 1, 8'h01, 48'h2,            64'h123690,          1'b1};
        vecs[10] = '{4'd1, 10'h055, 24'd0, 24'd0, 2'd0, 1'b0, 1, 1, 1, 8'h00, 48'h0,            64'h123790,          1'b0};
        vecs[11] = '{4'd6, 10'h37F, 24'd0, 24'd1, 2'd0, 1'b0, 2, 1, 2, 8'h01, 48'h1,            64'h123536790,       1'b0};
        vecs[12] = '{4'd2, 10'h001, 24'd0, 24'd0, 2'd0, 1'b0, 1, 0, 1, 8'h00, 48'h0,            64'h12390,           1'b1};
        vecs[13] = '{4'd0, 10'h002, 24'd1, 24'd1, 2'd0, 1'b1, 0, 0, 0, 8'h00, 48'h0,            64'h190,             1'b1};
        vecs[14] = '{4'd5, 10'h003, 24'd0, 24'd0, 2'd0, 1'b0, 0, 0, 0, 8'h00, 48'h0,            64'h1890,            1'b1};

        bus.cmd = '0; bus.cmd_vld = 1'b0; bus.addr = '0; bus.wr_len = '0; bus.rd_len = '0;
        bus.wfifo_empty = 1'b1; bus.rfifo_empty = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        check("reset_outputs", outs(), 0);
        check("reset_bus_held", dut.bus_held, 0);
        rst = 1'b0;
        @(posedge clock); #2;
        check("ready_after_reset", bus.cmd_ready, 1);

        for (int i = 0; i < 15; i++) begin
            t = $sformatf("v%0d", i);
            nack_sel = vecs[i].nack;
            issue(t, vecs[i].cmd, vecs[i].addr, vecs[i].wl, vecs[i].rl);
            wait_finish(t, err);
            nack_sel = 2'd0;
            check({t, "_err"}, err, vecs[i].err);
            check({t, "_err_held"}, bus.cmd_err, vecs[i].err);
            check({t, "_starts"}, starts, vecs[i].starts);
            check({t, "_stops"}, stops, vecs[i].stops);
            check({t, "_vld_cycles"}, vld_cycles, vecs[i].starts + vecs[i].stops);
            check({t, "_addr_phases"}, addrs, vecs[i].addrs);
            check({t, "_rw_log"}, rw_log, vecs[i].rw);
            check({t, "_len_log"}, len_log, vecs[i].lens);
            check({t, "_status_log"}, st_log, vecs[i].st);
            check({t, "_address_curr"}, bus.address_curr, {57'd0, vecs[i].addr[6:0]});
            check({t, "_bus_held"}, dut.bus_held, vecs[i].held);
        end

        // FIFO reset with a write FIFO that never drains: single pulses, then timeout error.
        bus.wfifo_empty = 1'b0;
        issue("fifo_tmo", 4'd5, 10'h004, 24'd0, 24'd0);
        wait_finish("fifo_tmo", err);
        bus.wfifo_empty = 1'b1;
        check("fifo_tmo_err", err, 1);
        check("fifo_tmo_wpulse", wpulses, 1);
        check("fifo_tmo_rpulse", rpulses, 1);
        check("fifo_tmo_wait_len", (fifo_wait >= (1 << TMO_W) - 1) && (fifo_wait <= (1 << TMO_W)),
              1);
        check("fifo_tmo_no_bus", vld_cycles, 0);
        check("fifo_tmo_status_log", st_log, 64'h1890);

        // Reset in the middle of a write phase, with the bus held from the earlier no-stop write.
        hold_wr = 1'b1;
        issue("rst_wr", 4'd1, 10'h02A, 24'd5, 24'd0);
        n = 0;
        while (!bus.exec_wr && n < 50) begin
            @(posedge clock); #2;
            n++;
        end
        check("rst_wr_reached", bus.exec_wr, 1);
        check("rst_wr_len", bus.exec_len, 5);
        rst = 1'b1;
        #1;
        check("rst_wr_outputs", outs(), 0);
        check("rst_wr_bus_held", dut.bus_held, 0);
        @(posedge clock); #2;
        rst = 1'b0;
        hold_wr = 1'b0;
        @(posedge clock); #2;
        check("rst_wr_ready", bus.cmd_ready, 1);
        issue("after_rst", 4'd1, 10'h050, 24'd1, 24'd0);
        wait_finish("after_rst", err);
        check("after_rst_err", err, 0);
        check("after_rst_starts", starts, 1);
        check("after_rst_status_log", st_log, 64'h1234790);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter ALEN, default 7, slave-address width; legal values 7 or 10.
REQ-002 SHALL have parameter LEN_W, default 24, burst-length width.
REQ-003 SHALL have parameter TMO_W, default 16, stage-timeout counter width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Ports, each as name direction width meaning:
- clock in 1: clock.
- rst in 1: asynchronous active-high reset.
- cmd in 4: command code.
- cmd_vld in 1: command valid.
- cmd_ready out 1: sequencer can accept a command.
- cmd_finish out 1: one-cycle completion pulse.
- cmd_err out 1: error flag, valid with cmd_finish.
- addr in 10: slave address; low ALEN bits used.
- wr_len in LEN_W: write byte count.
- rd_len in LEN_W: read byte count.
- curr_status out 4: state code.
- exec_addr out 1: address-phase request.
- exec_addr_rw out 1: R/W bit for the address phase; 1 = read.
- address_curr out ALEN: latched address.
- exec_len out LEN_W: byte count for the current data phase.
- exec_addr_finish in 1: address phase complete.
- exec_addr_nack in 1: slave NACK on the address phase.
- exec_wr out 1: write-phase request.
- exec_wr_finish in 1: write phase complete.
- exec_wr_nack in 1: NACK during the write phase.
- exec_rd out 1: read-phase request.
- exec_rd_finish in 1: read phase complete.
- tras_cmd_vld out 1: bit-layer command valid.
- tras_cmd out 3: bit-layer command; 1 = START, 4 = STOP.
- tras_cmd_ready in 1: bit layer accepts the command.
- wfifo_rst out 1: write-FIFO reset.
- rfifo_rst out 1: read-FIFO reset.
- wfifo_empty in 1: write FIFO empty.
- rfifo_empty in 1: read FIFO empty.

Function
REQ-006 Command codes SHALL be: 1 WR_STOP, 2 WR_NOSTOP, 3 RD_STOP, 4 RD_NOSTOP, 5 FIFO_RST, 6 WR_RD (write, repeated START, read, STOP). All other codes are illegal.
REQ-007 FSM states SHALL be IDLE, GET_CMD, START, ADDR, WR, RESTART, RD, STOP, FIFO_RST, FINISH, with curr_status codes 0 through 9 in that order.
REQ-008 cmd_ready SHALL be 1 only in IDLE. A command SHALL be accepted on cmd_vld && cmd_ready. On acceptance, cmd, addr[ALEN-1:0], wr_len and rd_len SHALL be latched into internal registers and address_curr.
REQ-009 GET_CMD transitions:
- illegal code, or a read-type command with rd_len = 0 -> FINISH with cmd_err = 1 and no bus activity.
- FIFO_RST -> FIFO_RST state.
- otherwise -> START.
REQ-010 START SHALL drive tras_cmd = 1 with tras_cmd_vld held high until tras_cmd_ready, then go to ADDR. A START issued while bus_held = 1 acts as a repeated START.
REQ-011 ADDR SHALL hold exec_addr high until exec_addr_finish. exec_addr_rw SHALL be 0 for write commands and for the first address phase of WR_RD, and 1 otherwise.
REQ-012 After ADDR, next state SHALL be:
- write phase pending, wr_len != 0 -> WR.
- write phase pending, wr_len = 0 (address probe) -> WR_RD goes to RESTART; other commands take the stop/no-stop path.
- read phase -> RD.
REQ-013 WR and RD SHALL hold exec_wr / exec_rd high until the matching finish. exec_len SHALL equal wr_len in WR and rd_len in RD.
REQ-014 After WR: WR_RD -> RESTART; WR_STOP -> STOP; WR_NOSTOP -> FINISH. After RD: RD_STOP and WR_RD -> STOP; RD_NOSTOP -> FINISH.
REQ-015 RESTART SHALL issue START as in REQ-010, then go to ADDR with exec_addr_rw = 1.
REQ-016 STOP SHALL drive tras_cmd = 4 with tras_cmd_vld held until tras_cmd_ready, then go to FINISH and clear bus_held.
REQ-017 bus_held SHALL be set when a *_NOSTOP command reaches FINISH without error.
REQ-018 An exec_addr_nack or exec_wr_nack asserted in ADDR or WR SHALL:
- take priority over a simultaneous finish;
- deassert the request the next cycle;
- go to STOP;
- set the error, reported as cmd_err = 1 with cmd_finish.
REQ-019 Timeout counter:
- TMO_W-bit counter clears on entry to ADDR, WR, RD, START, RESTART and STOP, and increments every cycle in those states.
- Reaching all-ones goes to STOP with error.
- A timeout in STOP itself goes to FINISH with error and clears bus_held.
REQ-020 FIFO_RST SHALL pulse wfifo_rst and rfifo_rst for exactly one cycle on entry, then wait until wfifo_empty && rfifo_empty, then go to FINISH. The wait is subject to the REQ-019 timeout.
REQ-021 FINISH SHALL pulse cmd_finish for one cycle with cmd_err valid, then return to IDLE. cmd_err SHALL hold until the next acceptance.
REQ-022 All outputs SHALL be registered. The request and tras_cmd_vld outputs SHALL assert the cycle after state entry.

Reset
REQ-023 While rst = 1, regardless of current state, outputs and state SHALL be:
- state IDLE, bus_held = 0;
- cmd_ready = 0, becoming 1 on the first clock after rst deasserts;
- every other output 0, including address_curr, exec_len and curr_status.

Verification
REQ-024 Cmd 1, addr 0x50, wr_len 3 -> sequence START, ADDR (rw = 0), WR (exec_len = 3), STOP; cmd_finish with cmd_err = 0; curr_status 0,1,2,3,4,7,9,0.
REQ-025 Cmd 6, wr_len 1, rd_len 4 -> two STARTs (second with bus_held = 0), address phases with rw 0 then 1, exec_len 1 then 4, one STOP, no error.
REQ-026 Cmd 2, then cmd 3 -> first command finishes with no STOP issued; second issues a repeated START; bus_held ends at 0.
REQ-027 exec_addr_nack = 1 together with exec_addr_finish in ADDR -> STOP issued, cmd_err = 1, WR never entered.
REQ-028 Cmd 5 with wfifo_empty held 0 -> one-cycle FIFO reset pulses, wait, timeout after 2^TMO_W-1 cycles -> cmd_err = 1; illegal cmd 9 -> cmd_err = 1 and tras_cmd_vld never asserted.
REQ-029 rst asserted during WR -> all outputs 0 in the same cycle; the next command starts with a fresh START.
